// File: rtl/pre_pkg.sv
// Shared constants for the programmable logic unit:
// mode encodings and common 3-input truth tables.
package pre_pkg;

    localparam logic MODE_PARALLEL = 1'b0;
    localparam logic MODE_STREAM   = 1'b1;

    localparam logic [7:0] TT_MAJ3 = 8'hE8;
    localparam logic [7:0] TT_XOR3 = 8'h96;

endpackage

// File: rtl/prog_logic_unit_if.sv
// Beat bus of the logic unit: input beat in,
// registered result out.
interface prog_logic_unit_if #(
    parameter int N_IN = 3
);
    logic            in_valid;
    logic [N_IN-1:0] a;
    logic            ser_in;
    logic            y;
    logic            y_valid;

    modport master (
        output in_valid,
        output a,
        output ser_in,
        input  y,
        input  y_valid
    );

    modport slave (
        input  in_valid,
        input  a,
        input  ser_in,
        output y,
        output y_valid
    );
endinterface

// File: rtl/plu_window.sv
// Sliding window over the serial stream with a
// saturating fill counter and two flush points.
module plu_window #(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            shift_en,
    input  logic            ser_in,
    input  logic            pre_flush,
    input  logic            post_flush,
    output logic [N_IN-1:0] win_next,
    output logic            full
);

    localparam int FW = $clog2(N_IN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(N_IN);
    localparam logic [FW-1:0] FILL_RDY = FW'(N_IN - 1);

    logic [N_IN-1:0] window;
    logic [N_IN-1:0] win_eff;
    logic [FW-1:0]   fill;
    logic [FW-1:0]   fill_eff;

    // pre_flush empties the window before this beat shifts in
    assign win_eff  = pre_flush ? '0 : window;
    assign fill_eff = pre_flush ? '0 : fill;

    assign win_next = (win_eff << 1) | N_IN'(ser_in);
    assign full     = fill_eff >= FILL_RDY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
            fill   <= '0;
        end else if (post_flush) begin
            window <= '0;
            fill   <= '0;
        end else if (shift_en) begin
            window <= win_next;
            fill   <= (fill_eff == FILL_MAX) ? FILL_MAX
                                             : fill_eff + 1'b1;
        end else if (pre_flush) begin
            window <= '0;
            fill   <= '0;
        end
    end

endmodule

// File: rtl/prog_logic_unit.sv
// Registered programmable N-input boolean unit with
// parallel and stream (pattern detect) modes.
module prog_logic_unit
    import pre_pkg::*;
#(
    parameter int                     N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0]   TT_RESET = TT_MAJ3,
    parameter int                     CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [(1<<N_IN)-1:0] cfg_tt,
    input  logic                 mode,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     hit_cnt,
    prog_logic_unit_if.slave     bus
);

    localparam int TT_W = 1 << N_IN;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TT_W-1:0] tt;
    logic            mode_q;
    logic            mode_chg;
    logic            shift_en;
    logic [N_IN-1:0] win_next;
    logic            win_full;
    logic [N_IN-1:0] idx;
    logic            emit;
    logic            res;
    logic            hit;
    logic            y_q;
    logic            yv_q;

    assign mode_chg = mode != mode_q;
    assign shift_en = bus.in_valid && (mode == MODE_STREAM);

    plu_window #(
        .N_IN(N_IN)
    ) u_win (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (shift_en),
        .ser_in     (bus.ser_in),
        .pre_flush  (mode_chg),
        .post_flush (cfg_we),
        .win_next   (win_next),
        .full       (win_full)
    );

    always_comb begin
        idx  = bus.a;
        emit = 1'b1;
        if (mode == MODE_STREAM) begin
            idx  = win_next;
            emit = win_full;
        end
    end

    // evaluated against the current table, so a
    // same-cycle cfg_we only affects later beats
    assign res = tt[idx];
    assign hit = bus.in_valid && emit && res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt      <= TT_RESET;
            mode_q  <= MODE_PARALLEL;
            y_q     <= 1'b0;
            yv_q    <= 1'b0;
            hit_cnt <= '0;
        end else begin
            if (cfg_we)
                tt <= cfg_tt;
            mode_q <= mode;
            yv_q   <= bus.in_valid && emit;
            if (bus.in_valid && emit)
                y_q <= res;
            if (cnt_clr)
                hit_cnt <= '0;
            else if (hit && hit_cnt != CNT_MAX)
                hit_cnt <= hit_cnt + 1'b1;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = yv_q;

endmodule

// File: tb/tb_prog_logic_unit.sv
// Scoreboard bench for prog_logic_unit: two instances
// (8-bit and 2-bit hit counters) share one stimulus.
module tb_prog_logic_unit;
  import pre_pkg::*;

  typedef struct {
    logic       y;
    logic       yv;
    logic [7:0] c;
    logic [1:0] c2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_tt = 8'h00;
  logic       mode = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [7:0] hit_cnt;
  logic [1:0] hit_cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];

  logic [7:0] m_tt;
  logic       m_mode;
  logic [2:0] m_win;
  int         m_fill;
  logic       m_y;
  logic       m_yv;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;

  always #5 clk = ~clk;

  prog_logic_unit_if #(.N_IN(3)) bus ();
  prog_logic_unit_if #(.N_IN(3)) bus2 ();

  assign bus2.in_valid = bus.in_valid;
  assign bus2.a        = bus.a;
  assign bus2.ser_in   = bus.ser_in;

  prog_logic_unit #(
    .N_IN(3), .TT_RESET(TT_MAJ3), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_tt(cfg_tt),
    .mode(mode), .cnt_clr(cnt_clr),
    .hit_cnt(hit_cnt), .bus(bus.slave)
  );

  prog_logic_unit #(
    .N_IN(3), .TT_RESET(TT_MAJ3), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_tt(cfg_tt),
    .mode(mode), .cnt_clr(cnt_clr),
    .hit_cnt(hit_cnt2), .bus(bus2.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_tt = TT_MAJ3; m_mode = MODE_PARALLEL;
    m_win = 3'b000; m_fill = 0;
    m_y = 1'b0; m_yv = 1'b0;
    m_cnt = 8'd0; m_cnt2 = 2'd0;
    q.delete();
  endtask

  task automatic step(input string tag,
                      input logic m, input logic v,
                      input logic [2:0] aa,
                      input logic s, input logic we,
                      input logic [7:0] tn,
                      input logic clr);
    logic em, r;
    exp_t e, g;
    mode = m; bus.in_valid = v; bus.a = aa;
    bus.ser_in = s; cfg_we = we; cfg_tt = tn;
    cnt_clr = clr;
    if (m != m_mode) begin
      m_win = 3'b000; m_fill = 0;
    end
    em = 1'b0; r = 1'b0;
    if (v) begin
      if (m == MODE_PARALLEL) begin
        r = m_tt[aa]; em = 1'b1;
      end else begin
        em = (m_fill >= 2);
        m_win = {m_win[1:0], s};
        if (m_fill < 3) m_fill++;
        r = m_tt[m_win];
      end
    end
    if (we) begin
      m_tt = tn; m_win = 3'b000; m_fill = 0;
    end
    m_mode = m;
    if (em) m_y = r;
    m_yv = em;
    if (clr) begin
      m_cnt = 8'd0; m_cnt2 = 2'd0;
    end else if (em && r) begin
      if (m_cnt != 8'hFF) m_cnt++;
      if (m_cnt2 != 2'd3) m_cnt2++;
    end
    e.y = m_y; e.yv = m_yv;
    e.c = m_cnt; e.c2 = m_cnt2;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, "_qempty"}, 1, 0);
    end else begin
      g = q.pop_front();
      chk({tag, "_y"}, 32'(bus.y), 32'(g.y));
      chk({tag, "_yv"}, 32'(bus.y_valid), 32'(g.yv));
      chk({tag, "_cnt"}, 32'(hit_cnt), 32'(g.c));
      chk({tag, "_cnt2"}, 32'(hit_cnt2), 32'(g.c2));
      chk({tag, "_y2"}, 32'(bus2.y), 32'(g.y));
    end
  endtask

  task automatic par(input string t, input logic [2:0] aa);
    step(t, MODE_PARALLEL, 1'b1, aa, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic str(input string t, input logic s);
    step(t, MODE_STREAM, 1'b1, 3'b000, s, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a = 3'b000;
    bus.ser_in = 1'b0;
    m_reset();
    #3;
    chk("rst_y", 32'(bus.y), 0);
    chk("rst_yv", 32'(bus.y_valid), 0);
    chk("rst_cnt", 32'(hit_cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // parallel with reset majority table
    par("p110", 3'b110);
    chk("p110_spec", 32'(bus.y), 1);
    par("p100", 3'b100);
    chk("p100_spec", 32'(bus.y), 0);
    step("idle", MODE_PARALLEL, 1'b0, 3'b111, 1'b0,
         1'b0, 8'h00, 1'b0);

    // reload with beat in same cycle uses old table
    step("cfg_old", MODE_PARALLEL, 1'b1, 3'b011, 1'b0,
         1'b1, TT_XOR3, 1'b0);
    chk("cfg_old_spec", 32'(bus.y), 1);
    par("cfg_new", 3'b011);
    chk("cfg_new_spec", 32'(bus.y), 0);
    par("xor111", 3'b111);

    // stream detector for 101
    step("cfg20", MODE_PARALLEL, 1'b0, 3'b000, 1'b0,
         1'b1, 8'h20, 1'b1);
    str("s1", 1'b1);
    str("s2", 1'b0);
    str("s3", 1'b1);
    str("s4", 1'b0);
    str("s5", 1'b1);
    chk("s5_cnt_spec", 32'(hit_cnt), 2);

    // mode toggle mid-window restarts fill
    str("s6", 1'b0);
    step("tog", MODE_PARALLEL, 1'b0, 3'b000, 1'b0,
         1'b0, 8'h00, 1'b0);
    str("t1", 1'b1);
    chk("t1_nov", 32'(bus.y_valid), 0);
    str("t2", 1'b0);
    chk("t2_nov", 32'(bus.y_valid), 0);
    str("t3", 1'b1);
    chk("t3_hit", 32'(bus.y), 1);

    // cfg_we flushes window after evaluating
    str("f1", 1'b0);
    step("fcfg", MODE_STREAM, 1'b1, 3'b000, 1'b1,
         1'b1, 8'h20, 1'b0);
    str("f2", 1'b0);
    str("f3", 1'b1);
    str("f4", 1'b0);

    // saturation of 2-bit counter and clear priority
    step("clr", MODE_PARALLEL, 1'b0, 3'b000, 1'b0,
         1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) par("sat", 3'b101);
    chk("sat_c2_spec", 32'(hit_cnt2), 3);
    chk("sat_c_spec", 32'(hit_cnt), 5);
    step("clrhit", MODE_PARALLEL, 1'b1, 3'b101, 1'b0,
         1'b0, 8'h00, 1'b1);
    chk("clrhit_spec", 32'(hit_cnt2), 0);

    // random parallel/stream mix
    for (int i = 0; i < 40; i++)
      step("rnd", 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 14) == 0));

    // async reset mid-stream
    step("rcfg", MODE_STREAM, 1'b0, 3'b000, 1'b0,
         1'b1, 8'h20, 1'b0);
    str("r1", 1'b1);
    str("r2", 1'b0);
    str("r3", 1'b1);
    chk("r3_hit", 32'(bus.y), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_y", 32'(bus.y), 0);
    chk("ar_yv", 32'(bus.y_valid), 0);
    chk("ar_cnt", 32'(hit_cnt), 0);
    m_reset();
    mode = MODE_PARALLEL;
    bus.in_valid = 1'b0;
    cfg_we = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    par("ar_011", 3'b011);
    chk("ar_tt_spec", 32'(bus.y), 1);
    par("ar_001", 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
